// File: rtl/audio_stream_engine_pkg.sv
// ============================================================================
//  Module : audio_stream_engine_pkg
//  Brief  : Shared mode encodings, counter widths and helpers for the audio
//           stream engine.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package audio_stream_engine_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'b00,
        MODE_PROCESS = 2'b01,
        MODE_MUTE    = 2'b10,
        MODE_ATTEN   = 2'b11
    } mode_e;

    localparam int FRAME_CNT_W = 32;
    localparam int STALL_CNT_W = 16;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/audio_stream_engine_fifo.sv
// ============================================================================
//  Module : audio_stream_engine_fifo
//  Brief  : Synchronous frame FIFO with occupancy count and cut-through of a
//           frame pushed into an empty buffer.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module audio_stream_engine_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && pop_i) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers advance together on a cut-through, so they stay equal while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign pop_data_o = (count_q == '0) ? push_data_i : mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(push_i && !pop_i && (count_q == c_cnt_w'(DEPTH))));
            assert (!(pop_i && !push_i && (count_q == '0)));
        end
    end

endmodule

`default_nettype wire

// File: rtl/audio_stream_engine.sv
// ============================================================================
//  Module : audio_stream_engine
//  Brief  : Credit-controlled ADC FIFO -> processor -> DAC FIFO frame mover
//           with per-frame mode select and status counters.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module audio_stream_engine
    import audio_stream_engine_pkg::*;
#(
    parameter int SAMPLE_W     = 16,
    parameter int CHANNELS     = 2,
    parameter int PROC_LATENCY = 4,
    parameter int OUT_DEPTH    = 8,
    parameter int ATTEN_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [1:0]                   mode_i,
    input  logic [ATTEN_W-1:0]           atten_i,
    input  logic                         adcfifo_empty_i,
    output logic                         adcfifo_read_o,
    input  logic [SAMPLE_W*CHANNELS-1:0] adcfifo_readdata_i,
    output logic [SAMPLE_W*CHANNELS-1:0] proc_in_o,
    input  logic [SAMPLE_W*CHANNELS-1:0] proc_out_i,
    input  logic                         dacfifo_full_i,
    output logic                         dacfifo_write_o,
    output logic [SAMPLE_W*CHANNELS-1:0] dacfifo_writedata_o,
    output logic [FRAME_CNT_W-1:0]       frame_cnt_o,
    output logic [STALL_CNT_W-1:0]       stall_cnt_o
);

    localparam int                 c_frame_w = SAMPLE_W * CHANNELS;
    localparam int                 c_cnt_w   = $clog2(OUT_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(OUT_DEPTH);
    localparam int                 c_tail    = PROC_LATENCY - 1;

    logic                     rd_pend_q;
    logic                     s0_valid_q;
    logic [c_frame_w-1:0]     s0_data_q;
    logic [1:0]               s0_mode_q;
    logic [ATTEN_W-1:0]       s0_atten_q;

    logic                     dl_valid_q [PROC_LATENCY];
    logic [c_frame_w-1:0]     dl_data_q  [PROC_LATENCY];
    logic [1:0]               dl_mode_q  [PROC_LATENCY];
    logic [ATTEN_W-1:0]       dl_atten_q [PROC_LATENCY];

    logic [c_cnt_w-1:0]       inflight_q;
    logic [c_cnt_w-1:0]       inflight_d;
    logic [c_cnt_w-1:0]       buf_count;

    logic                     w_read;
    logic                     w_push;
    logic                     w_pending;
    logic                     w_pop;
    logic [c_frame_w-1:0]     w_out_frame;
    logic [c_frame_w-1:0]     w_pop_data;

    logic                     dac_write_q;
    logic [c_frame_w-1:0]     dac_data_q;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q;
    logic [STALL_CNT_W-1:0]   stall_cnt_q;

    // Every frame already read holds a reserved buffer slot until it is popped.
    assign w_read    = reset_n & ~adcfifo_empty_i & ((buf_count + inflight_q) < c_depth);
    assign w_push    = dl_valid_q[c_tail];
    assign w_pending = (buf_count != '0) | w_push;
    assign w_pop     = w_pending & ~dacfifo_full_i;

    always_comb begin
        inflight_d = inflight_q + c_cnt_w'(w_read) - c_cnt_w'(w_push);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q  <= 1'b0;
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            s0_mode_q  <= '0;
            s0_atten_q <= '0;
            inflight_q <= '0;
        end else begin
            rd_pend_q  <= w_read;
            s0_valid_q <= rd_pend_q;
            inflight_q <= inflight_d;
            if (rd_pend_q) begin
                s0_data_q  <= adcfifo_readdata_i;
                s0_mode_q  <= mode_i;
                s0_atten_q <= atten_i;
            end
        end
    end

    assign proc_in_o = s0_data_q;

    // Raw frame and its control travel alongside the processor so they meet proc_out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < PROC_LATENCY; k++) begin
                dl_valid_q[k] <= 1'b0;
                dl_data_q[k]  <= '0;
                dl_mode_q[k]  <= '0;
                dl_atten_q[k] <= '0;
            end
        end else begin
            dl_valid_q[0] <= s0_valid_q;
            dl_data_q[0]  <= s0_data_q;
            dl_mode_q[0]  <= s0_mode_q;
            dl_atten_q[0] <= s0_atten_q;
            for (int k = 1; k < PROC_LATENCY; k++) begin
                dl_valid_q[k] <= dl_valid_q[k-1];
                dl_data_q[k]  <= dl_data_q[k-1];
                dl_mode_q[k]  <= dl_mode_q[k-1];
                dl_atten_q[k] <= dl_atten_q[k-1];
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [SAMPLE_W-1:0] w_raw;
        logic        [SAMPLE_W-1:0] w_sel;

        assign w_raw = dl_data_q[c_tail][c*SAMPLE_W +: SAMPLE_W];

        always_comb begin
            w_sel = '0;
            unique case (mode_e'(dl_mode_q[c_tail]))
                MODE_BYPASS:  w_sel = w_raw;
                MODE_PROCESS: w_sel = proc_out_i[c*SAMPLE_W +: SAMPLE_W];
                MODE_MUTE:    w_sel = '0;
                MODE_ATTEN:   w_sel = $unsigned(w_raw >>> dl_atten_q[c_tail]);
            endcase
        end

        assign w_out_frame[c*SAMPLE_W +: SAMPLE_W] = w_sel;
    end

    audio_stream_engine_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (c_frame_w)
    ) u_out_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (w_push),
        .push_data_i (w_out_frame),
        .pop_i       (w_pop),
        .pop_data_o  (w_pop_data),
        .count_o     (buf_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dac_write_q <= 1'b0;
            dac_data_q  <= '0;
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            dac_write_q <= w_pop;
            if (w_pop) begin
                dac_data_q  <= w_pop_data;
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (w_pending && dacfifo_full_i) begin
                stall_cnt_q <= sat_inc(stall_cnt_q);
            end
        end
    end

    assign adcfifo_read_o      = w_read;
    assign dacfifo_write_o     = dac_write_q;
    assign dacfifo_writedata_o = dac_data_q;
    assign frame_cnt_o         = frame_cnt_q;
    assign stall_cnt_o         = stall_cnt_q;

endmodule

`default_nettype wire
